// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - request/result handshake bundle for the shift-add multiplier
interface shift_add_multiplier_if;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential 8x8 unsigned multiplier driving an external 8-bit adder
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  mul,
  output logic [7:0]             addA,
  output logic [7:0]             addB,
  output logic                   addEn,
  input  logic [7:0]             addSum,
  input  logic                   addCarry
);

  generate
    if (WIDTH != 8) begin : g_bad_width
      $error("shift_add_multiplier: WIDTH must be 8 to match the external adder");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  acc;
  logic [7:0]  q;
  logic [7:0]  m;
  logic [2:0]  cnt;
  logic [15:0] product;
  logic        busy;
  logic        done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mul.start) begin
            m     <= mul.multiplicand;
            q     <= mul.multiplier;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Shift the 9-bit adder result right through the {acc, q} pair.
          acc <= {addCarry, addSum[7:1]};
          q   <= {addSum[0], q[7:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            product <= {addCarry, addSum[7:1], addSum[0], q[7:1]};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    addA  = 8'h00;
    addB  = 8'h00;
    addEn = 1'b0;
    if (state == RUN) begin
      addA  = acc;
      addB  = q[0] ? m : 8'h00;
      addEn = 1'b1;
    end
  end

  assign mul.busy    = busy;
  assign mul.done    = done;
  assign mul.product = product;

endmodule
